// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Nibble index width; never narrower than one bit so single-nibble builds still elaborate.
    function automatic int idx_w(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_cla4_add.sv
// rtl/nibble_serial_adder_cla4_add.sv - combinational 4-bit carry-lookahead adder stage
module cla4_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin_i);

    assign s_o    = p ^ c[3:0];
    assign cout_o = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - sequences WIDTH-bit adds through one 4-bit CLA stage, LSB nibble first
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW      = idx_w(NIBBLES);

    state_t                               state_q, state_d;
    logic [WIDTH-1:0]                     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                                 carry_q, carry_d;
    logic [IW-1:0]                        idx_q, idx_d;
    logic                                 fin_q, fin_d;
    logic                                 cout_q, cout_d, ovf_q, ovf_d;
    logic                                 in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [NIBBLES-1:0][NIBBLE_W-1:0]     a_nibs, b_nibs, sum_nibs;
    logic [NIBBLE_W-1:0]                  nib_s;
    logic                                 nib_cout;

    assign a_nibs = a_q;
    assign b_nibs = b_q;

    cla4_add u_cla4_add (
        .a_i    (a_nibs[idx_q]),
        .b_i    (b_nibs[idx_q]),
        .cin_i  (carry_q),
        .s_o    (nib_s),
        .cout_o (nib_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        fin_d    = fin_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        sum_nibs = sum_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    fin_d   = 1'b0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The cycle after the last nibble only publishes flags from the completed SUM.
                if (fin_q) begin
                    cout_d  = carry_q;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    sum_nibs[idx_q] = nib_s;
                    sum_d           = sum_nibs;
                    carry_d         = nib_cout;
                    if (idx_q == IW'(NIBBLES - 1)) begin
                        fin_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            fin_q       <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            fin_q       <= fin_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks  = 0;
    int   errors  = 0;
    int   n_acc   = 0;
    int   n_cons  = 0;
    int   n_abort = 0;
    exp_t q[$];

    nibble_serial_adder_if #(.WIDTH(16)) bus ();

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        exp_t        r;
        logic [16:0] t;
        t      = {1'b0, a} + {1'b0, b} + {16'd0, c};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        return r;
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    // Scoreboard: handshakes are evaluated mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (rst) begin
            n_abort += q.size();
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("mon_spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    chk("mon_sum",  {16'd0, bus.sum}, {16'd0, q[0].sum});
                    chk("mon_cout", {31'd0, bus.cout}, {31'd0, q[0].cout});
                    chk("mon_ovf",  {31'd0, bus.ovf}, {31'd0, q[0].ovf});
                    chk("mon_in_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_cons++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.cin));
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 100) begin
            tick();
            edges++;
        end
        if (edges >= 100) chk("out_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                            input logic [15:0] es, input logic ec, input logic eo, input int hold);
        exp_t m;
        int   e;
        m = model(a, b, c);
        chk({tag, "_model"}, {14'd0, m.sum, m.cout, m.ovf}, {14'd0, es, ec, eo});
        send(a, b, c);
        wait_out(e);
        chk({tag, "_latency"}, e, 32'd5);
        chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
        chk({tag, "_cout_ovf"}, {30'd0, bus.cout, bus.ovf}, {30'd0, ec, eo});
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.a        = 16'h0F0F;
            bus.b        = 16'h1111;
            tick();
            chk({tag, "_hold_sum"}, {16'd0, bus.sum}, {16'd0, es});
            chk({tag, "_hold_flags"}, {29'd0, bus.cout, bus.ovf, bus.in_ready}, {29'd0, ec, eo, 1'b0});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_after_consume"}, {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin
        int acc_before;
        int cons_before;
        int abort_before;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_state", {12'd0, bus.sum, bus.cout, bus.ovf, bus.in_ready, bus.out_valid},
            {12'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        rst = 1'b0;
        tick();

        directed("add_5555",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        directed("ripple",    16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        directed("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        directed("neg_ovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        directed("wrap",      16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        acc_before = n_acc;
        directed("backpress", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 10);
        chk("backpress_no_queued_accept", n_acc - acc_before, 32'd1);

        abort_before = n_abort;
        send(16'h00FF, 16'h0001, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {13'd0, bus.sum, bus.out_valid, bus.in_ready}, {13'd0, 16'h0000, 1'b0, 1'b1});
        chk("abort_dropped", n_abort - abort_before, 32'd1);
        directed("post_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        cons_before = n_cons;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic hs;
                    int   n;
                    if ($urandom_range(0, 3) == 0) tick();
                    bus.a        = 16'($urandom);
                    bus.b        = 16'($urandom);
                    bus.cin      = 1'($urandom_range(0, 1));
                    bus.in_valid = 1'b1;
                    n  = 0;
                    hs = 1'b0;
                    while (!hs && n < 200) begin
                        hs = bus.in_ready;
                        tick();
                        n++;
                    end
                    if (!hs) chk("rand_send_timeout", 32'd1, 32'd0);
                    bus.in_valid = 1'b0;
                end
            end
            begin
                int cyc;
                cyc = 0;
                while ((n_cons - cons_before) < 1000 && cyc < 60000) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                    cyc++;
                end
                bus.out_ready = 1'b0;
            end
        join
        repeat (3) tick();
        chk("rand_consumed", n_cons - cons_before, 32'd1000);
        chk("queue_empty", q.size(), 32'd0);
        chk("handshake_balance", n_acc, n_cons + n_abort);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
